// File: rtl/smg_pkg.sv
// ------------------------------------------------------------------
// smg_pkg: shared types and constants for the ADC-to-display path.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package smg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2,
    HOLD = 2'd3
  } smg_state_e;

  localparam int          SMG_DIGITS      = 4;
  localparam int          SMG_BCD_W       = 16;
  localparam int unsigned SMG_OVER_THRESH = 4000;

  // Double-dabble correction applied to a nibble before each shift.
  function automatic logic [3:0] smg_add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/smg_bin2bcd.sv
// ------------------------------------------------------------------
// smg_bin2bcd: sequential shift/add-3 binary to BCD converter.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module smg_bin2bcd
  import smg_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    bin_in,
  output logic                 done,
  output logic [SMG_BCD_W-1:0] bcd_out
);

  localparam int c_CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]    r_shift;
  logic [SMG_BCD_W-1:0] r_acc;
  logic [SMG_BCD_W-1:0] w_adj;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_busy;

  for (genvar gi = 0; gi < SMG_DIGITS; gi++) begin : g_digit
    assign w_adj[gi*4 +: 4] = smg_add3(r_acc[gi*4 +: 4]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (start) begin
      r_shift <= bin_in;
      r_acc   <= '0;
      r_cnt   <= c_CNT_W'(DATA_W);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_acc   <= (w_adj << 1) | SMG_BCD_W'(r_shift[DATA_W-1]);
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt - c_CNT_W'(1);
      if (r_cnt == c_CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign done    = r_busy && (r_cnt == c_CNT_W'(1));
  assign bcd_out = r_acc;

endmodule

`default_nettype wire

// File: rtl/smg_adc_ctrl.sv
// ------------------------------------------------------------------
// smg_adc_ctrl: accepts ADC samples, converts to BCD, holds display.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module smg_adc_ctrl
  import smg_pkg::*;
#(
  parameter int          DATA_W      = 12,
  parameter int unsigned HOLD_CYCLES = 5_000_000,
  parameter int unsigned OVER_THRESH = SMG_OVER_THRESH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    sample_data,
  output logic                 sample_ready,
  output logic [SMG_BCD_W-1:0] bcd_digits,
  output logic                 digit_update,
  output logic                 over_led
);

  localparam int                  c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);

  smg_state_e           r_state;
  smg_state_e           w_next;
  logic                 r_ready;
  logic                 r_over_pend;
  logic                 r_update;
  logic                 r_over;
  logic [SMG_BCD_W-1:0] r_digits;
  logic [c_HOLD_W-1:0]  r_hold;
  logic                 w_accept;
  logic                 w_done;
  logic [SMG_BCD_W-1:0] w_bcd;

  assign w_accept = sample_valid && r_ready;

  smg_bin2bcd #(
    .DATA_W (DATA_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (w_accept),
    .bin_in  (sample_data),
    .done    (w_done),
    .bcd_out (w_bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CONV;
      CONV:    if (w_done) w_next = LOAD;
      LOAD:    w_next = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      HOLD:    if (r_hold == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ready is registered from the next state so it falls on the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready     <= 1'b0;
      r_over_pend <= 1'b0;
      r_update    <= 1'b0;
      r_over      <= 1'b0;
      r_digits    <= '0;
      r_hold      <= '0;
    end else begin
      r_ready  <= (w_next == IDLE);
      r_update <= (r_state == LOAD);
      if (w_accept) begin
        r_over_pend <= (32'(sample_data) >= OVER_THRESH);
      end
      if (r_state == LOAD) begin
        r_digits <= w_bcd;
        r_over   <= r_over_pend;
        if (HOLD_CYCLES != 0) begin
          r_hold <= c_HOLD_LOAD;
        end
      end else if ((r_state == HOLD) && (r_hold != '0)) begin
        r_hold <= r_hold - c_HOLD_W'(1);
      end
    end
  end

  assign sample_ready = r_ready;
  assign bcd_digits   = r_digits;
  assign digit_update = r_update;
  assign over_led     = r_over;

endmodule

`default_nettype wire

// File: tb/tb_smg_adc_ctrl.sv
// ------------------------------------------------------------------
// tb_smg_adc_ctrl: two controllers (hold 4 and hold 0) against a model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_smg_adc_ctrl;

  localparam int DW     = 12;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 0;

  typedef struct packed {
    int          age;
    int          val;
    logic        rdy;
    logic        upd;
    logic        ovr;
    logic [15:0] dig;
  } mstate_t;

  localparam mstate_t M_RST = '{age: -1, val: 0, rdy: 1'b0, upd: 1'b0, ovr: 1'b0, dig: 16'h0};

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          valid_a = 1'b0;
  logic          valid_b = 1'b0;
  logic [DW-1:0] data_a  = '0;
  logic [DW-1:0] data_b  = '0;
  logic          ready_a, ready_b, upd_a, upd_b, over_a, over_b;
  logic [15:0]   dig_a, dig_b;

  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc      = 0;
  mstate_t m [2];

  logic [DW-1:0] c_edge_vals [5] = '{12'd0, 12'd1, 12'd3999, 12'd4000, 12'd4095};

  smg_adc_ctrl #(.DATA_W(DW), .HOLD_CYCLES(HOLD_A), .OVER_THRESH(4000)) dut_a (
    .clk(clk), .rst(rst), .sample_valid(valid_a), .sample_data(data_a),
    .sample_ready(ready_a), .bcd_digits(dig_a), .digit_update(upd_a), .over_led(over_a));

  smg_adc_ctrl #(.DATA_W(DW), .HOLD_CYCLES(HOLD_B), .OVER_THRESH(4000)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(valid_b), .sample_data(data_b),
    .sample_ready(ready_b), .bcd_digits(dig_b), .digit_update(upd_b), .over_led(over_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // age counts edges since acceptance; -1 means waiting for a sample.
  function automatic mstate_t model_step(input mstate_t s, input int hold, input logic vld, input int din);
    mstate_t n;
    n     = s;
    n.upd = 1'b0;
    if (s.age >= 0) begin
      n.age = s.age + 1;
      if (n.age == DW + 1) begin
        n.dig = to_bcd(s.val);
        n.upd = 1'b1;
        n.ovr = (s.val >= 4000);
      end
      if (n.age == DW + 1 + hold) n.age = -1;
    end
    if (s.rdy && vld) begin
      n.age = 0;
      n.val = din;
    end
    n.rdy = (n.age == -1);
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m[0] <= M_RST;
      m[1] <= M_RST;
    end else begin
      m[0] <= model_step(m[0], HOLD_A, valid_a, int'(data_a));
      m[1] <= model_step(m[1], HOLD_B, valid_b, int'(data_b));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a.sample_ready", 32'(ready_a), 32'(m[0].rdy));
    chk("a.bcd_digits",   32'(dig_a),   32'(m[0].dig));
    chk("a.digit_update", 32'(upd_a),   32'(m[0].upd));
    chk("a.over_led",     32'(over_a),  32'(m[0].ovr));
    chk("b.sample_ready", 32'(ready_b), 32'(m[1].rdy));
    chk("b.bcd_digits",   32'(dig_b),   32'(m[1].dig));
    chk("b.digit_update", 32'(upd_b),   32'(m[1].upd));
    chk("b.over_led",     32'(over_b),  32'(m[1].ovr));
  end

  // Returns just after the accepting edge E0.
  task automatic send_a(input logic [DW-1:0] v);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_a) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: sample_ready=%0b required 1", ready_a);
    end
    valid_a = 1'b1;
    data_a  = v;
    @(negedge clk);
    valid_a = 1'b0;
    data_a  = 12'($urandom);
  endtask

  task automatic conv_a(input logic [DW-1:0] v, input logic [15:0] exp_dig, input logic exp_over);
    send_a(v);
    repeat (13) @(negedge clk);
    chk("conv.bcd_digits", 32'(dig_a), 32'(exp_dig));
    chk("conv.over_led",   32'(over_a), 32'(exp_over));
    chk("conv.update",     32'(upd_a), 32'd1);
  endtask

  initial begin
    int seen, last_a, last_b, nd_a, nd_b;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst.ready",  32'(ready_a), 32'd0);
    chk("rst.digits", 32'(dig_a),   32'h0);
    chk("rst.update", 32'(upd_a),   32'd0);
    chk("rst.over",   32'(over_a),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.ready_rise", 32'(ready_a), 32'd1);

    conv_a(12'd0,    16'h0000, 1'b0);
    conv_a(12'd1234, 16'h1234, 1'b0);
    conv_a(12'd4095, 16'h4095, 1'b1);

    // Asynchronous reset while idle with a non-zero display.
    repeat (5) @(negedge clk);
    chk("idle.ready", 32'(ready_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async.digits", 32'(dig_a),   32'h0);
    chk("async.over",   32'(over_a),  32'd0);
    chk("async.ready",  32'(ready_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("async.ready_rise", 32'(ready_a), 32'd1);

    conv_a(12'd3999, 16'h3999, 1'b0);

    // Reset during the sixth conversion cycle.
    send_a(12'd4000);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midconv.digits", 32'(dig_a), 32'h0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (upd_a) seen++;
    end
    chk("midconv.no_update", 32'(seen), 32'd0);
    chk("midconv.digits_kept", 32'(dig_a), 32'h0);

    conv_a(12'd4000, 16'h4000, 1'b1);
    conv_a(12'd1234, 16'h1234, 1'b0);

    // Latency of a 0x7FF sample.
    send_a(12'h7FF);
    repeat (12) @(negedge clk);
    chk("lat.e12_update", 32'(upd_a), 32'd0);
    @(negedge clk);
    chk("lat.e13_digits", 32'(dig_a), 32'h2047);
    chk("lat.e13_update", 32'(upd_a), 32'd1);
    @(negedge clk);
    chk("lat.e14_update", 32'(upd_a), 32'd0);
    repeat (2) @(negedge clk);
    chk("lat.e16_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    chk("lat.e17_ready", 32'(ready_a), 32'd1);

    // Continuous valid with data changing every cycle.
    last_a  = -1;
    last_b  = -1;
    nd_a    = 0;
    nd_b    = 0;
    valid_a = 1'b1;
    valid_b = 1'b1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      data_a = 12'($urandom);
      data_b = 12'($urandom);
      if (ready_a) begin
        if (last_a >= 0 && nd_a < 5) begin
          chk("bp.a_spacing", 32'(cyc - last_a), 32'd18);
          nd_a++;
        end
        last_a = cyc;
      end
      if (ready_b) begin
        if (last_b >= 0 && nd_b < 5) begin
          chk("bp.b_spacing", 32'(cyc - last_b), 32'd14);
          nd_b++;
        end
        last_b = cyc;
      end
    end
    chk("bp.a_accepts", 32'(nd_a), 32'd5);
    chk("bp.b_accepts", 32'(nd_b), 32'd5);

    // Random traffic with boundary values mixed in.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      valid_a = ($urandom_range(0, 3) != 0);
      valid_b = ($urandom_range(0, 3) != 0);
      data_a  = ($urandom_range(0, 3) == 0) ? c_edge_vals[$urandom_range(0, 4)] : 12'($urandom_range(0, 4095));
      data_b  = ($urandom_range(0, 3) == 0) ? c_edge_vals[$urandom_range(0, 4)] : 12'($urandom_range(0, 4095));
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
